// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer
// Streams a complete MIPS state dump through the UART transmitter after a halt
// or a debug step. The word order is PC, clock-cycle count, every register-file
// entry, then every data-memory word. Each word is sent most-significant byte
// first.
//
// Ports
//   clk_wz           in   system clock, rising edge
//   i_reset          in   synchronous active-high reset
//   i_start          in   one-cycle dump request (honoured in IDLE only)
//   i_tx_done        in   one-cycle pulse from tx when the current byte is finished
//   i_pc             in   program counter
//   i_clk_count      in   executed-cycle counter
//   i_data_reg_file  in   register-file read data for o_select_reg_dir
//   i_data_mem       in   data-memory read data for o_select_mem_dir
//   o_select_reg_dir out  register read index
//   o_select_mem_dir out  data-memory word index
//   o_tx_data        out  byte presented to tx
//   o_tx_start       out  one-cycle start pulse to tx
//   o_busy           out  high from acceptance of i_start until DONE
//   o_done           out  one-cycle pulse after the final byte completes
module debug_dump_sequencer #(
  parameter int NBITS     = 32,
  parameter int DATA_BITS = 8,
  parameter int SIZE_REG  = 32,
  parameter int SIZE_M    = 16,
  parameter int READ_LAT  = 1
) (
  input  logic                        clk_wz,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic                        i_tx_done,
  input  logic [NBITS-1:0]            i_pc,
  input  logic [NBITS-1:0]            i_clk_count,
  input  logic [NBITS-1:0]            i_data_reg_file,
  input  logic [NBITS-1:0]            i_data_mem,
  output logic [$clog2(SIZE_REG)-1:0] o_select_reg_dir,
  output logic [NBITS-1:0]            o_select_mem_dir,
  output logic [DATA_BITS-1:0]        o_tx_data,
  output logic                        o_tx_start,
  output logic                        o_busy,
  output logic                        o_done
);

  // state   | meaning
  // IDLE    | waiting for i_start; selects hold their last value
  // SELECT  | selects already point at word w; load the latency timer
  // SETTLE  | count read latency down; capture word w at terminal count
  // SEND    | o_tx_start high for one cycle with the current byte
  // WAIT    | hold o_tx_data until i_tx_done, then next byte/word or DONE
  // DONE    | o_done pulse, o_busy low, back to IDLE
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SELECT = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_SEND   = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam int NWORDS    = 2 + SIZE_REG + SIZE_M;
  localparam int WCNT_W    = $clog2(NWORDS);
  localparam int NBYTES    = NBITS / DATA_BITS;
  localparam int BCNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int REG_SEL_W = $clog2(SIZE_REG);
  localparam int LAT_W     = 2;

  localparam logic [WCNT_W-1:0] REG_LO    = WCNT_W'(2);
  localparam logic [WCNT_W-1:0] MEM_LO    = WCNT_W'(SIZE_REG + 2);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NWORDS - 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NBYTES - 1);

  logic [2:0]        state;
  logic [WCNT_W-1:0] word_cnt;
  logic [BCNT_W-1:0] byte_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [NBITS-1:0]  shreg;
  logic [NBITS-1:0]  capture_word;
  logic              load_sel;
  logic [WCNT_W-1:0] next_word;

  // Selects are updated on the same edge that enters SELECT, so the read
  // latency window starts with the SELECT cycle itself.
  always_comb begin
    load_sel  = 1'b0;
    next_word = word_cnt;
    if (state == ST_IDLE && i_start) begin
      load_sel  = 1'b1;
      next_word = '0;
    end else if (state == ST_WAIT && i_tx_done && byte_cnt == LAST_BYTE &&
                 word_cnt != LAST_WORD) begin
      load_sel  = 1'b1;
      next_word = word_cnt + WCNT_W'(1);
    end
  end

  always_comb begin
    capture_word = i_data_mem;
    if (word_cnt == '0)
      capture_word = i_pc;
    else if (word_cnt == WCNT_W'(1))
      capture_word = i_clk_count;
    else if (word_cnt < MEM_LO)
      capture_word = i_data_reg_file;
  end

  always_ff @(posedge clk_wz) begin
    if (i_reset) begin
      state            <= ST_IDLE;
      word_cnt         <= '0;
      byte_cnt         <= '0;
      lat_cnt          <= '0;
      shreg            <= '0;
      o_select_reg_dir <= '0;
      o_select_mem_dir <= '0;
    end else begin
      if (load_sel) begin
        // Out-of-range selects are left alone so the buses do not toggle.
        if (next_word >= REG_LO && next_word < MEM_LO)
          o_select_reg_dir <= REG_SEL_W'(next_word - REG_LO);
        if (next_word >= MEM_LO)
          o_select_mem_dir <= NBITS'(next_word - MEM_LO);
      end

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            word_cnt <= '0;
            byte_cnt <= '0;
            state    <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          lat_cnt <= LAT_W'(READ_LAT);
          state   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (lat_cnt == '0) begin
            shreg <= capture_word;
            state <= ST_SEND;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        ST_SEND: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_tx_done) begin
            if (byte_cnt != LAST_BYTE) begin
              shreg    <= {shreg[NBITS-DATA_BITS-1:0], {DATA_BITS{1'b0}}};
              byte_cnt <= byte_cnt + BCNT_W'(1);
              state    <= ST_SEND;
            end else if (word_cnt != LAST_WORD) begin
              word_cnt <= next_word;
              byte_cnt <= '0;
              state    <= ST_SELECT;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // All handshake outputs are decoded from the state register, so they are
  // glitch-free and drop to zero on the reset edge.
  assign o_tx_data  = shreg[NBITS-1 -: DATA_BITS];
  assign o_tx_start = (state == ST_SEND);
  assign o_busy     = (state != ST_IDLE) && (state != ST_DONE);
  assign o_done     = (state == ST_DONE);

endmodule

// File: tb/tb_debug_dump_sequencer.sv
module tb_debug_dump_sequencer;

  localparam int NREG   = 32;
  localparam int NMEM   = 16;
  localparam int NWORDS = 2 + NREG + NMEM;
  localparam int NBYTES = NWORDS * 4;

  typedef struct {
    logic [7:0] b;
    int         kind;   // 0: pc/clk word, 1: register word, 2: memory word
    int         idx;
  } exp_t;

  logic clk_wz = 1'b0;
  always #5 clk_wz = ~clk_wz;

  int cyc = 0;
  always @(posedge clk_wz) cyc <= cyc + 1;

  logic        dsel;
  logic        rst_all, rst_drv, start_drv, done_drv, man_done;
  logic [31:0] pc, clk_count;

  logic        rst0, rst1, start0, start1, done0, done1;
  logic [4:0]  rsel0, rsel1;
  logic [31:0] msel0, msel1;
  logic [7:0]  txd0, txd1;
  logic        st0, st1, busy0, busy1, dn0, dn1;

  logic [31:0] reg_q0, mem_q0;
  logic [4:0]  rs_d1, rs_d2, rs_d3;
  logic [31:0] ms_d1, ms_d2, ms_d3;
  logic [31:0] reg_q1, mem_q1;

  assign rst0   = rst_all | (rst_drv & ~dsel);
  assign rst1   = rst_all | (rst_drv & dsel);
  assign start0 = start_drv & ~dsel;
  assign start1 = start_drv & dsel;
  assign done0  = (done_drv & ~dsel) | man_done;
  assign done1  = done_drv & dsel;

  // Read-port models: one register stage for the default latency, a
  // three-deep select pipeline for the slow instance.
  always @(posedge clk_wz) begin
    reg_q0 <= 32'hA000_0000 + 32'(rsel0);
    mem_q0 <= 32'h0000_5500 + msel0;
    rs_d1  <= rsel1;
    rs_d2  <= rs_d1;
    rs_d3  <= rs_d2;
    ms_d1  <= msel1;
    ms_d2  <= ms_d1;
    ms_d3  <= ms_d2;
  end
  assign reg_q1 = 32'hA000_0000 + 32'(rs_d3);
  assign mem_q1 = 32'h0000_5500 + ms_d3;

  debug_dump_sequencer u_dut0 (
    .clk_wz          (clk_wz),
    .i_reset         (rst0),
    .i_start         (start0),
    .i_tx_done       (done0),
    .i_pc            (pc),
    .i_clk_count     (clk_count),
    .i_data_reg_file (reg_q0),
    .i_data_mem      (mem_q0),
    .o_select_reg_dir(rsel0),
    .o_select_mem_dir(msel0),
    .o_tx_data       (txd0),
    .o_tx_start      (st0),
    .o_busy          (busy0),
    .o_done          (dn0)
  );

  debug_dump_sequencer #(.READ_LAT(3)) u_dut1 (
    .clk_wz          (clk_wz),
    .i_reset         (rst1),
    .i_start         (start1),
    .i_tx_done       (done1),
    .i_pc            (pc),
    .i_clk_count     (clk_count),
    .i_data_reg_file (reg_q1),
    .i_data_mem      (mem_q1),
    .o_select_reg_dir(rsel1),
    .o_select_mem_dir(msel1),
    .o_tx_data       (txd1),
    .o_tx_start      (st1),
    .o_busy          (busy1),
    .o_done          (dn1)
  );

  logic [4:0]  cur_rsel;
  logic [31:0] cur_msel;
  logic [7:0]  cur_txd;
  logic        cur_st, cur_busy, cur_dn;
  assign cur_rsel = dsel ? rsel1 : rsel0;
  assign cur_msel = dsel ? msel1 : msel0;
  assign cur_txd  = dsel ? txd1  : txd0;
  assign cur_st   = dsel ? st1   : st0;
  assign cur_busy = dsel ? busy1 : busy0;
  assign cur_dn   = dsel ? dn1   : dn0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [4:0] prev_rsel;
  int   t_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and note when the register select moves.
  task automatic tick();
    @(negedge clk_wz);
    if (cur_rsel !== prev_rsel) begin
      prev_rsel = cur_rsel;
      t_sel     = cyc;
    end
  endtask

  task automatic push_dump();
    logic [31:0] wv;
    exp_t        e;
    for (int w = 0; w < NWORDS; w++) begin
      e.kind = 0;
      e.idx  = 0;
      if (w == 0) wv = pc;
      else if (w == 1) wv = clk_count;
      else if (w < NREG + 2) begin
        wv = 32'hA000_0000 + 32'(w - 2);
        e.kind = 1;
        e.idx  = w - 2;
      end else begin
        wv = 32'h0000_5500 + 32'(w - 2 - NREG);
        e.kind = 2;
        e.idx  = w - 2 - NREG;
      end
      for (int b = 0; b < 4; b++) begin
        e.b = wv[31 - 8*b -: 8];
        sb.push_back(e);
      end
    end
  endtask

  task automatic watch_quiet(input string tag, input int n);
    int starts = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (cur_st === 1'b1) starts++;
    end
    check(tag, 32'(starts), 32'd0);
  endtask

  task automatic do_dump(input int rl, input int restart_at, input int abort_at);
    exp_t e;
    bit   seen;
    sb.delete();
    push_dump();
    start_drv = 1'b1;
    tick();
    start_drv = 1'b0;
    check("busy_after_start", 32'(cur_busy), 32'd1);
    for (int k = 0; k < NBYTES; k++) begin
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
        if (cur_st === 1'b1) seen = 1'b1;
        else tick();
      end
      check("tx_start_timeout", 32'(seen), 32'd1);
      if (!seen) return;
      e = sb.pop_front();
      check($sformatf("tx_byte[%0d]", k), 32'(cur_txd), 32'(e.b));
      if (e.kind == 1) check("reg_select", 32'(cur_rsel), 32'(e.idx));
      if (e.kind == 2) check("mem_select", cur_msel, 32'(e.idx));
      if (e.kind == 1 && (k % 4) == 0 && e.idx > 0)
        check("select_to_start", 32'(cyc - t_sel), 32'(rl + 2));
      tick();
      check("start_single_cycle", 32'(cur_st), 32'd0);
      if (k == abort_at) begin
        tick();
        rst_drv = 1'b1;
        tick();
        rst_drv = 1'b0;
        check("abort_busy", 32'(cur_busy), 32'd0);
        check("abort_start", 32'(cur_st), 32'd0);
        check("abort_txdata", 32'(cur_txd), 32'd0);
        check("abort_reg_sel", 32'(cur_rsel), 32'd0);
        check("abort_mem_sel", cur_msel, 32'd0);
        check("abort_done", 32'(cur_dn), 32'd0);
        sb.delete();
        return;
      end
      if (k == restart_at) start_drv = 1'b1;
      tick();
      start_drv = 1'b0;
      tick();
      tick();
      done_drv = 1'b1;
      tick();
      done_drv = 1'b0;
      if (k == NBYTES - 1) begin
        check("done_pulse", 32'(cur_dn), 32'd1);
        check("busy_low_with_done", 32'(cur_busy), 32'd0);
        tick();
        check("done_one_cycle", 32'(cur_dn), 32'd0);
      end else begin
        check("no_early_done", 32'(cur_dn), 32'd0);
      end
    end
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    watch_quiet("no_start_after_dump", 10);
  endtask

  initial begin
    dsel      = 1'b0;
    rst_all   = 1'b1;
    rst_drv   = 1'b0;
    start_drv = 1'b0;
    done_drv  = 1'b0;
    man_done  = 1'b0;
    pc        = 32'h0000_0010;
    clk_count = 32'h0000_0007;
    prev_rsel = '0;
    t_sel     = 0;
    repeat (3) tick();
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_start", 32'(st0), 32'd0);
    check("reset_done", 32'(dn0), 32'd0);
    check("reset_txdata", 32'(txd0), 32'd0);
    check("reset_reg_sel", 32'(rsel0), 32'd0);
    check("reset_mem_sel", msel0, 32'd0);
    check("reset_busy_slow", 32'(busy1), 32'd0);
    rst_all = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) begin
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      tick();
      check("idle_done_no_start", 32'(st0), 32'd0);
      check("idle_done_busy", 32'(busy0), 32'd0);
    end
    check("idle_txdata", 32'(txd0), 32'd0);
    check("idle_reg_sel", 32'(rsel0), 32'd0);

    do_dump(1, 50, -1);
    pc        = 32'h1234_5678;
    clk_count = 32'hCAFE_0001;
    do_dump(1, -1, -1);
    do_dump(1, -1, 90);
    watch_quiet("no_start_after_abort", 8);
    pc        = 32'h0040_00FC;
    clk_count = 32'h0000_0BAD;
    do_dump(1, -1, -1);

    dsel = 1'b1;
    tick();
    do_dump(3, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
